// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants; also imported by the decoder.
// Optional macro FETCH_RESET_OPC_EN is consumed by fetch_unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } fetch_state_t;

  localparam logic [3:0] OPC_RESET = 4'b1111;

  localparam int unsigned PC_W_DEF     = 8;
  localparam int unsigned RESET_PC_DEF = 0;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with load, increment and natural modulo-2^PC_W wrap.
// Load beats increment when both are requested.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-entry instruction fetch: IDLE/REQ/FULL FSM plus instruction register.
// Macro FETCH_RESET_OPC_EN: handing off an OPC_RESET word reloads RESET_PC.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_rdata,
  input  logic            imem_valid,
  output logic [7:0]      inst_out,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target
);

  fetch_state_t state, state_nx;

  logic            fire;
  logic            handoff;
  logic            pc_load;
  logic            pc_inc;
  logic [PC_W-1:0] pc_val;
  logic [PC_W-1:0] pc;

  assign fire    = (state == REQ) && imem_valid;
  assign handoff = (state == FULL) && inst_ready;

  // Redirect always wins; a word landing with it is simply not captured.
  always_comb begin
    pc_load = branch_taken;
    pc_val  = branch_target;
    pc_inc  = 1'b0;
    if (!branch_taken) begin
      pc_inc = fire;
`ifdef FETCH_RESET_OPC_EN
      if (handoff && (inst_out[7:4] == OPC_RESET)) begin
        pc_load = 1'b1;
        pc_val  = RESET_PC;
      end
`endif
    end
  end

  fetch_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (pc_load),
    .load_val (pc_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (branch_taken) begin
      state_nx = REQ;
    end else begin
      unique case (state)
        IDLE:    state_nx = REQ;
        REQ:     if (imem_valid) state_nx = FULL;
        FULL:    if (inst_ready) state_nx = REQ;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req  = (state == REQ);
    imem_addr = pc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inst_out   <= 8'h00;
      inst_valid <= 1'b0;
    end else if (branch_taken) begin
      inst_valid <= 1'b0;
    end else if (fire) begin
      inst_out   <= imem_rdata;
      inst_valid <= 1'b1;
    end else if (handoff) begin
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit, plus async-reset sequences.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_valid;
  logic [7:0] inst_out;
  logic       inst_valid;
  logic       inst_ready;
  logic       branch_taken;
  logic [7:0] branch_target;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef FETCH_RESET_OPC_EN
  localparam logic [7:0] OPC_NEXT = 8'h00;
`else
  localparam logic [7:0] OPC_NEXT = 8'h06;
`endif

  fetch_unit dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .inst_out      (inst_out),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mv;
    logic [7:0] rd;
    logic       rdy;
    logic       br;
    logic [7:0] tgt;
    logic       ereq;
    logic [7:0] eaddr;
    logic       evld;
    logic [7:0] eout;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    logic mv, logic [7:0] rd, logic rdy,
    logic br, logic [7:0] tgt,
    logic ereq, logic [7:0] eaddr,
    logic evld, logic [7:0] eout
  );
    vec_t v;
    v.mv = mv; v.rd = rd; v.rdy = rdy;
    v.br = br; v.tgt = tgt;
    v.ereq = ereq; v.eaddr = eaddr;
    v.evld = evld; v.eout = eout;
    return v;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic r, logic [7:0] a,
                         logic v, logic [7:0] o);
    chk({tag, ".imem_req"},   8'(imem_req),   8'(r));
    chk({tag, ".imem_addr"},  imem_addr,      a);
    chk({tag, ".inst_valid"}, 8'(inst_valid), 8'(v));
    chk({tag, ".inst_out"},   inst_out,       o);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    imem_valid    = 1'b0;
    imem_rdata    = 8'h00;
    inst_ready    = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 8'h00;
  endtask

  initial begin
    // mv rd rdy br tgt | req addr vld out
    tv.push_back(mk(0,8'h00,1,0,8'h00, 0,8'h00,0,8'h00)); // IDLE
    tv.push_back(mk(1,8'h1A,1,0,8'h00, 1,8'h00,0,8'h00)); // zero wait
    tv.push_back(mk(0,8'h00,1,0,8'h00, 0,8'h01,1,8'h1A)); // handoff
    tv.push_back(mk(0,8'h00,0,0,8'h00, 1,8'h01,0,8'h1A)); // wait 1
    tv.push_back(mk(0,8'h00,0,0,8'h00, 1,8'h01,0,8'h1A)); // wait 2
    tv.push_back(mk(0,8'h00,0,0,8'h00, 1,8'h01,0,8'h1A)); // wait 3
    tv.push_back(mk(1,8'h22,0,0,8'h00, 1,8'h01,0,8'h1A)); // late word
    tv.push_back(mk(0,8'h00,0,0,8'h00, 0,8'h02,1,8'h22)); // hold 1
    tv.push_back(mk(0,8'h00,0,0,8'h00, 0,8'h02,1,8'h22)); // hold 2
    tv.push_back(mk(0,8'h00,0,0,8'h00, 0,8'h02,1,8'h22)); // hold 3
    tv.push_back(mk(0,8'h00,0,0,8'h00, 0,8'h02,1,8'h22)); // hold 4
    tv.push_back(mk(0,8'h00,1,0,8'h00, 0,8'h02,1,8'h22)); // consume
    tv.push_back(mk(1,8'h33,1,1,8'h40, 1,8'h02,0,8'h22)); // br+valid
    tv.push_back(mk(1,8'h44,0,0,8'h00, 1,8'h40,0,8'h22)); // at target
    tv.push_back(mk(0,8'h00,1,1,8'h80, 0,8'h41,1,8'h44)); // br+ready
    tv.push_back(mk(0,8'h00,1,0,8'h00, 1,8'h80,0,8'h44)); // flushed
    tv.push_back(mk(0,8'h00,0,1,8'hFF, 1,8'h80,0,8'h44)); // to FF
    tv.push_back(mk(1,8'h55,0,0,8'h00, 1,8'hFF,0,8'h44)); // fetch FF
    tv.push_back(mk(0,8'h00,1,0,8'h00, 0,8'h00,1,8'h55)); // wrapped
    tv.push_back(mk(0,8'h00,0,0,8'h00, 1,8'h00,0,8'h55)); // req 00
    tv.push_back(mk(0,8'h00,0,1,8'h05, 1,8'h00,0,8'h55)); // to 05
    tv.push_back(mk(1,8'hF3,0,0,8'h00, 1,8'h05,0,8'h55)); // fetch F3
    tv.push_back(mk(0,8'h00,1,0,8'h00, 0,8'h06,1,8'hF3)); // hand F3
    tv.push_back(mk(1,8'hF0,0,0,8'h00, 1,OPC_NEXT,0,8'hF3));

    reset_n = 1'b0;
    idle_in();
    tick();
    tick();
    chk_all("rst", 1'b0, 8'h00, 1'b0, 8'h00);
    reset_n = 1'b1;

    foreach (tv[i]) begin
      imem_valid    = tv[i].mv;
      imem_rdata    = tv[i].rd;
      inst_ready    = tv[i].rdy;
      branch_taken  = tv[i].br;
      branch_target = tv[i].tgt;
      chk_all($sformatf("v%0d", i), tv[i].ereq, tv[i].eaddr,
              tv[i].evld, tv[i].eout);
      tick();
    end

    // Held in FULL with F0: reset drops it without a clock edge.
    idle_in();
    chk_all("full", 1'b0, OPC_NEXT + 8'h01, 1'b1, 8'hF0);
    #3;
    reset_n = 1'b0;
    #1;
    chk_all("arst_full", 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    reset_n = 1'b1;
    chk_all("rel_idle", 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    chk_all("rel_req", 1'b1, 8'h00, 1'b0, 8'h00);

    // Reset mid-request after moving away from RESET_PC.
    branch_taken  = 1'b1;
    branch_target = 8'h30;
    tick();
    idle_in();
    chk_all("req30", 1'b1, 8'h30, 1'b0, 8'h00);
    #3;
    reset_n = 1'b0;
    #1;
    chk_all("arst_req", 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    reset_n = 1'b1;
    tick();
    imem_valid = 1'b1;
    imem_rdata = 8'h77;
    chk_all("req_again", 1'b1, 8'h00, 1'b0, 8'h00);
    tick();
    idle_in();
    chk_all("full_again", 1'b0, 8'h01, 1'b1, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 8, SHALL set the program counter and instruction-memory address width.
REQ-002 Parameter RESET_PC, default 0, SHALL set the PC value loaded at reset.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 imem_req  output  1  SHALL be high while an instruction read is requested.
REQ-006 imem_addr  output  PC_W  SHALL carry the read address, always equal to the current PC.
REQ-007 imem_rdata  input  8  instruction word from memory.
REQ-008 imem_valid  input  1  SHALL mean imem_rdata is the word for the current imem_addr; it is meaningful only while imem_req is high.
REQ-009 inst_out  output  8  held instruction word driven to the decoder.
REQ-010 inst_valid  output  1  SHALL be high when inst_out holds an unconsumed instruction.
REQ-011 inst_ready  input  1  SHALL be asserted by the consumer to accept inst_out.
REQ-012 branch_taken  input  1  one-cycle redirect pulse from execute.
REQ-013 branch_target  input  PC_W  redirect address, sampled only when branch_taken is high.

Function
REQ-014 The FSM SHALL have three states: IDLE, REQ and FULL.
REQ-015 IDLE SHALL last exactly one cycle after reset release, then move to REQ.
REQ-016 In REQ, imem_req SHALL be 1; in IDLE and FULL it SHALL be 0.
REQ-017 In REQ with imem_valid=1, the block SHALL set inst_out<=imem_rdata, inst_valid<=1 and pc<=pc+1, and move to FULL.
REQ-018 imem_valid SHALL be accepted in the same cycle imem_req rises (zero-wait memory); wait cycles are unbounded.
REQ-019 In FULL, inst_out and inst_valid SHALL stay stable until inst_ready=1.
REQ-020 In FULL with inst_ready=1, the block SHALL set inst_valid<=0 and move to REQ; peak throughput is one instruction per 2 cycles.
REQ-021 PC increment SHALL wrap modulo 2^PC_W (all-ones -> 0).
REQ-022 branch_taken SHALL have priority over all other events in every state: pc<=branch_target, inst_valid<=0, next state REQ.
REQ-023 An imem_valid arriving in the same cycle as branch_taken SHALL be discarded.
REQ-024 A held instruction SHALL be flushed by branch_taken even if inst_ready is high in that cycle, so that no handoff occurs.
REQ-025 branch_taken in IDLE SHALL load the target and enter REQ.
REQ-026 inst_ready while inst_valid=0 SHALL have no effect.

Reset
REQ-027 On reset_n=0, the block SHALL immediately force pc=RESET_PC, state=IDLE, inst_out=8'h00, inst_valid=0 and imem_req=0, regardless of clk.
REQ-028 Reset asserted mid-request or mid-hold SHALL drop the pending word; after release, the first request SHALL be to RESET_PC.

Configuration
REQ-029 Macro FETCH_RESET_OPC_EN, when defined, SHALL make the handoff in FULL of a word whose opcode bits [7:4]=4'b1111 also set pc<=RESET_PC, overriding the increment; branch_taken in the same cycle still wins.
REQ-030 Without FETCH_RESET_OPC_EN, opcode 4'b1111 SHALL be treated like any other word, and the PC advances normally.

Structure
REQ-031 A shared package fetch_pkg SHALL hold the FSM state enum, the constant OPC_RESET=4'b1111, and the default PC_W/RESET_PC values.
REQ-032 The opcode constant SHALL be shared with the decoder through fetch_pkg, not redefined locally.
REQ-033 A single sub-module, fetch_pc_reg, SHALL hold the PC with load/increment/wrap; the FSM and instruction register SHALL stay in fetch_unit.

Verification
REQ-034 Reset release, memory answers 0x1A at 0 with zero wait, inst_ready=1 -> imem_addr=0 in cycle 2, inst_out=0x1A with inst_valid in cycle 3, next request to 1.
REQ-035 imem_valid delayed 3 cycles, then inst_ready held low 4 cycles -> imem_req high all 4 REQ cycles, inst_out stable throughout, no address change.
REQ-036 PC=0xFF, fetch consumed -> next imem_addr=0x00.
REQ-037 branch_taken with target 0x40 in the same cycle as imem_valid -> word discarded, inst_valid stays 0, next imem_addr=0x40; repeat in FULL with inst_ready=1 -> no handoff.
REQ-038 With FETCH_RESET_OPC_EN, word 0xF3 fetched at 0x05 and consumed -> next imem_addr=RESET_PC; without the macro -> next imem_addr=0x06.
REQ-039 reset_n pulsed low while in FULL -> inst_valid falls asynchronously, and the first request after release is to RESET_PC.
